// File: rtl/binomial_sampler_pkg.sv
// Shared definitions for the centred-binomial (k=8) polynomial sampler.
//   - Modulus offset, polynomial geometry and datapath widths.
//   - Upstream buffer select encodings and FSM state encodings.
//   - popcnt8: Hamming weight of one SHAKE byte.
package binomial_sampler_pkg;

  localparam int Q      = 12289;  // offset added to every coefficient
  localparam int N      = 512;    // coefficients per polynomial
  localparam int WORDS  = 64;     // 128-bit buffer words per polynomial (N/8)
  localparam int COEF_W = 14;     // Q+8 = 12297 fits in 14 bits
  localparam int ADDR_W = 9;      // log2(N)
  localparam int WORD_W = 128;    // buffer word width
  localparam int BYTE_W = 8;
  localparam int SEL_W  = 2;
  localparam int CTR_W  = 6;      // word counter, 0..WORDS-1
  localparam int K_W    = 3;      // coefficient index within a word, 0..7
  localparam int NBUF   = 3;      // number of upstream buffers

  // Which upstream shift-RAM buffer feeds this run; SEL_NONE is rejected.
  typedef enum logic [SEL_W-1:0] {
    SEL_BUF0 = 2'd0,
    SEL_BUF1 = 2'd1,
    SEL_BUF2 = 2'd2,
    SEL_NONE = 2'd3
  } buf_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  function automatic logic [3:0] popcnt8(input logic [BYTE_W-1:0] b);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < BYTE_W; i++) cnt = cnt + 4'(b[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/binomial_sampler_cbd.sv
// cbd_coef: one centred-binomial (k=8) coefficient, purely combinational.
//   byte_a, byte_b : two SHAKE output bytes
//   coef           : hw(byte_a) + Q - hw(byte_b), range [Q-8, Q+8], not reduced
// Kept as a stand-alone block so a two-coefficient-per-cycle variant can
// instantiate two copies side by side.
module cbd_coef
  import binomial_sampler_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_a,
  input  logic [BYTE_W-1:0] byte_b,
  output logic [COEF_W-1:0] coef
);

  logic [3:0] hw_a;
  logic [3:0] hw_b;

  always_comb begin
    hw_a = popcnt8(byte_a);
    hw_b = popcnt8(byte_b);
    // Q >= 8 so the subtraction never wraps.
    coef = COEF_W'(Q) + COEF_W'(hw_a) - COEF_W'(hw_b);
  end

endmodule

// File: rtl/binomial_sampler.sv
// binomial_sampler: drains one 128-bit upstream buffer (64 words) and writes
// 512 centred-binomial coefficients sequentially into a polynomial RAM.
//   clk, rst            : clock, synchronous active-high reset
//   start, sel          : one-cycle start pulse and buffer select (0..2)
//   busy, done          : run in progress / one-cycle completion pulse
//   bs_en_0..2          : advance pulse to the selected upstream buffer
//   SO_0..2             : head word of each upstream buffer
//   coef_we/addr/di     : polynomial RAM write port (registered)
// Per word: one FETCH cycle latches the head word and advances the buffer,
// then eight EMIT cycles produce one coefficient each (9 cycles per word).
module binomial_sampler
  import binomial_sampler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              bs_en_0,
  output logic              bs_en_1,
  output logic              bs_en_2,
  input  logic [WORD_W-1:0] SO_0,
  input  logic [WORD_W-1:0] SO_1,
  input  logic [WORD_W-1:0] SO_2,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_di
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [CTR_W-1:0]   word_ctr;
  logic [K_W-1:0]     k;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  so_mux;
  logic [WORD_W-1:0]  word_sh;
  logic [BYTE_W-1:0]  byte_a;
  logic [BYTE_W-1:0]  byte_b;
  logic [COEF_W-1:0]  coef;
  logic [NBUF-1:0]    bs_en;
  logic               last_k;
  logic               last_word;

  assign last_k    = (k == K_W'(7));
  assign last_word = (word_ctr == CTR_W'(WORDS - 1));

  // Head word of the buffer selected for this run.
  always_comb begin
    so_mux = '0;
    case (sel_q)
      SEL_BUF0: so_mux = SO_0;
      SEL_BUF1: so_mux = SO_1;
      SEL_BUF2: so_mux = SO_2;
      default:  so_mux = '0;
    endcase
  end

  // The first SHAKE byte sits in the MSBs; shifting by 16*k brings pair k to
  // the top so byte_a/byte_b are fixed slices of the shifted word.
  assign word_sh = word_q << {k, 4'b0000};
  assign byte_a  = word_sh[WORD_W-1 -: BYTE_W];
  assign byte_b  = word_sh[WORD_W-1-BYTE_W -: BYTE_W];

  cbd_coef u_cbd (
    .byte_a (byte_a),
    .byte_b (byte_b),
    .coef   (coef)
  );

  // Next state and buffer advance. bs_en is combinational from FETCH so the
  // buffer steps in the same cycle the head word is latched; it is forced
  // low during reset so a mid-run reset never advances the buffer.
  always_comb begin
    state_d = state_q;
    bs_en   = '0;
    case (state_q)
      IDLE: begin
        if (start && (sel != SEL_NONE)) state_d = FETCH;
      end
      FETCH: begin
        state_d = EMIT;
        case (sel_q)
          SEL_BUF0: bs_en[0] = 1'b1;
          SEL_BUF1: bs_en[1] = 1'b1;
          SEL_BUF2: bs_en[2] = 1'b1;
          default:  bs_en    = '0;
        endcase
      end
      EMIT: begin
        if (last_k) state_d = last_word ? FINISH : FETCH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) bs_en = '0;
  end

  assign bs_en_0 = bs_en[0];
  assign bs_en_1 = bs_en[1];
  assign bs_en_2 = bs_en[2];

  // Control and write-port registers. busy/done are registered from the
  // next state so they line up with state_q: busy covers FETCH..FINISH and
  // done coincides with the last write appearing on the RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      coef_we   <= 1'b0;
      coef_addr <= '0;
      coef_di   <= '0;
      word_ctr  <= '0;
      k         <= '0;
      sel_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == FINISH);
      coef_we <= (state_q == EMIT);
      case (state_q)
        IDLE: begin
          if (state_d == FETCH) begin
            sel_q    <= sel;
            word_ctr <= '0;
            k        <= '0;
          end
        end
        EMIT: begin
          // word_ctr*8 + k is just the concatenation.
          coef_addr <= {word_ctr, k};
          coef_di   <= coef;
          if (last_k) begin
            k <= '0;
            // Hold at WORDS-1 on the final word; FINISH ends the run.
            if (!last_word) word_ctr <= word_ctr + CTR_W'(1);
          end else begin
            k <= k + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Word register carries no control meaning, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == FETCH) word_q <= so_mux;
  end

endmodule

// File: tb/tb_binomial_sampler.sv
// Self-checking bench for binomial_sampler. A behavioural model of the three
// upstream buffers feeds SO_x; expected writes are pushed to a scoreboard
// queue when each run is started and popped as coef_we writes appear.
module tb_binomial_sampler;
  import binomial_sampler_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SEL_W-1:0]  sel;
  logic              busy, done;
  logic              bs_en_0, bs_en_1, bs_en_2;
  logic [WORD_W-1:0] SO_0, SO_1, SO_2;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_di;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic [WORD_W-1:0] bufmem [NBUF][WORDS];
  int   ptr [NBUF] = '{0, 0, 0};
  logic refill = 1'b0;
  exp_t sb [$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   bs_cnt [NBUF] = '{0, 0, 0};
  int   done_cnt = 0;
  int   ram [N];

  always #5 clk = ~clk;

  binomial_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .bs_en_0   (bs_en_0),
    .bs_en_1   (bs_en_1),
    .bs_en_2   (bs_en_2),
    .SO_0      (SO_0),
    .SO_1      (SO_1),
    .SO_2      (SO_2),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_di   (coef_di)
  );

  // Upstream buffer model: head word visible, advance on bs_en.
  assign SO_0 = bufmem[0][ptr[0]];
  assign SO_1 = bufmem[1][ptr[1]];
  assign SO_2 = bufmem[2][ptr[2]];

  always @(posedge clk) begin
    if (refill) begin
      for (int x = 0; x < NBUF; x++) ptr[x] <= 0;
    end else begin
      if (bs_en_0) ptr[0] <= (ptr[0] + 1) % WORDS;
      if (bs_en_1) ptr[1] <= (ptr[1] + 1) % WORDS;
      if (bs_en_2) ptr[2] <= (ptr[2] + 1) % WORDS;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, expv);
    end
  endtask

  // Monitor: pulse counters and scoreboard compare, sampled on negedge.
  always @(negedge clk) begin
    if (bs_en_0) bs_cnt[0]++;
    if (bs_en_1) bs_cnt[1]++;
    if (bs_en_2) bs_cnt[2]++;
    if (done) done_cnt++;
    if (coef_we) begin
      ram[coef_addr] = int'(coef_di);
      if (sb.size() == 0) begin
        chk("extra_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", int'(coef_addr), e.addr);
        chk("wr_data", int'(coef_di), e.data);
      end
    end
  end

  function automatic logic [WORD_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: centred binomial from the buffer words about to be consumed.
  task automatic push_exp(input int x);
    logic [WORD_W-1:0] wd;
    logic [7:0] a, b;
    for (int w = 0; w < WORDS; w++) begin
      wd = bufmem[x][(ptr[x] + w) % WORDS];
      for (int j = 0; j < 8; j++) begin
        a = 8'(wd >> (120 - 16 * j));
        b = 8'(wd >> (112 - 16 * j));
        sb.push_back('{w * 8 + j, Q + $countones(a) - $countones(b)});
      end
    end
  endtask

  // Full run on buffer x; if mid_sel >= 0 a stray start is pulsed mid-run.
  task automatic run(input int x, input int mid_sel);
    int cyc;
    bs_cnt = '{0, 0, 0};
    done_cnt = 0;
    push_exp(x);
    @(negedge clk);
    sel = SEL_W'(x);
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    while (!done && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (start) start = 1'b0;
      else if (mid_sel >= 0 && cyc == 50) begin
        sel = SEL_W'(mid_sel);
        start = 1'b1;
      end
    end
    chk("latency", cyc, 576);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("we_after_done", coef_we, 0);
    chk("done_pulses", done_cnt, 1);
    for (int i = 0; i < NBUF; i++)
      chk($sformatf("bs_en_%0d_cnt", i), bs_cnt[i], (i == x) ? WORDS : 0);
    chk("ptr_wrap", ptr[x], 0);
    chk("sb_left", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sel = '0;
    for (int w = 0; w < WORDS; w++) begin
      bufmem[0][w] = '0;
      bufmem[1][w] = rnd128();
      bufmem[2][w] = rnd128();
    end
    bufmem[1][0] = {8{16'hFF00}};
    bufmem[1][1] = {8{16'h00FF}};
    bufmem[2][0] = {48'h0103_F00F_7F00, 80'(rnd128())};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", coef_we, 0);
    chk("rst_addr", int'(coef_addr), 0);
    chk("rst_di", int'(coef_di), 0);
    chk("rst_bs_en", int'({bs_en_2, bs_en_1, bs_en_0}), 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero buffer 0.
    run(0, -1);
    chk("zero_last", ram[N-1], Q);

    // sel==3 in IDLE is ignored.
    bs_cnt = '{0, 0, 0};
    done_cnt = 0;
    sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("sel3_busy", busy, 0);
    chk("sel3_done", done_cnt, 0);
    chk("sel3_bs_en", bs_cnt[0] + bs_cnt[1] + bs_cnt[2], 0);

    // Buffer 1 with a stray start (sel=2) during the run.
    run(1, 2);
    chk("ff00_0", ram[0], 12297);
    chk("ff00_7", ram[7], 12297);
    chk("00ff_8", ram[8], 12281);
    chk("00ff_15", ram[15], 12281);

    // Buffer 2 with specific byte pairs at the top of word 0.
    run(2, -1);
    chk("pair_0", ram[0], 12288);
    chk("pair_1", ram[1], 12289);
    chk("pair_2", ram[2], 12296);

    // Reset mid-run on a random buffer 0.
    for (int w = 0; w < WORDS; w++) bufmem[0][w] = rnd128();
    done_cnt = 0;
    push_exp(0);
    @(negedge clk);
    sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", coef_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bs_en", int'({bs_en_2, bs_en_1, bs_en_0}), 0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("midrst_done", done_cnt, 0);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    run(0, -1);

    // Back-to-back runs on fresh random fills.
    for (int x = 0; x < NBUF; x++)
      for (int w = 0; w < WORDS; w++) bufmem[x][w] = rnd128();
    for (int x = 0; x < NBUF; x++) run(x, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binomial_sampler.md
Name: binomial_sampler

Overview:
- Consumes one of the three 128-bit shift-RAM buffers (SO_0/SO_1/SO_2) filled by the SHAKE256 sampler buffer stage.
- Converts each 16-bit slice into one centred-binomial (k=8) coefficient: hw(byte_a) + Q - hw(byte_b).
- Writes the coefficients sequentially into a polynomial RAM.
- Sits directly downstream of the sampler buffer. The upstream stage honours bs_en_x only while in its idle state, so start is issued only after the upstream done pulse.

Parameters:
- Q, 12289, modulus added as offset.
- N, 512, coefficients per polynomial.
- WORDS, 64, buffer words per polynomial; must equal N/8.
- COEF_W, 14, coefficient width; Q+8 = 12297 < 2^14.
- ADDR_W, 9, log2(N).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins sampling of buffer sel
- sel  in  2  buffer select: 0, 1, 2; value 3 is invalid
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last coefficient write
- bs_en_0 / bs_en_1 / bs_en_2  out  1 each  advance pulse to the upstream buffers
- SO_0 / SO_1 / SO_2  in  128 each  head word of each upstream buffer
- coef_we  out  1  polynomial RAM write enable
- coef_addr  out  ADDR_W  write address
- coef_di  out  COEF_W  write data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Reset forces state IDLE and zeroes busy, done, coef_we, coef_addr, coef_di, word_ctr, k and sel_q. bs_en_* are low while in reset.
- Buffer interface: SO_x shows the head word. Asserting bs_en_x for one cycle advances the buffer; the next word is valid from the following cycle.
- State IDLE: on start with sel<3, latch sel_q=sel, clear word_ctr and k, go to FETCH. start with sel==3 is ignored and done is not pulsed. start in any other state is ignored.
- State FETCH (1 cycle):
  - word_q <= SO_[sel_q].
  - bs_en_[sel_q]=1, driven combinationally from state and sel_q; the other two enables stay 0.
  - Go to EMIT.
- State EMIT (8 cycles, k = 0..7):
  - byte_a = word_q[127-16k -: 8]; byte_b = word_q[119-16k -: 8]. The first SHAKE byte is the MSB byte.
  - Registered outputs: coef_we <= 1; coef_addr <= word_ctr*8 + k; coef_di <= popcount(byte_a) + Q - popcount(byte_b).
  - Each coefficient lies in [Q-8, Q+8] and is not reduced mod Q.
  - Write latency is one cycle after the EMIT cycle.
  - At k==7: if word_ctr==WORDS-1, go to FINISH; else increment word_ctr, clear k, go to FETCH.
- State FINISH (1 cycle): coef_we=0, done=1, then return to IDLE.
- Timing:
  - 9 cycles per word, 576 cycles from start to done.
  - The last write (addr 511) is visible on the RAM port in the FINISH cycle; done is high in that same cycle.
- Exactly WORDS bs_en pulses are issued per run, so the upstream buffer is fully drained and returns to its post-reset contents.
- coef_we is low in every cycle other than the registered outputs of EMIT.
- Reset mid-run: immediate return to IDLE, no done pulse. The buffer is left partially consumed and the upstream stage must refill it before a new start.
- Address wrap: coef_addr never exceeds N-1; word_ctr is 6 bits and saturates via the FINISH transition.

Decomposition:
- Shared package: Q, N, COEF_W, ADDR_W, the buffer select encodings, and the state encodings IDLE / FETCH / EMIT / FINISH.
- One sub-module, cbd_coef: purely combinational. Takes two 8-bit inputs and outputs COEF_W bits (two 8-bit popcounts plus the Q offset). It is reusable for a parallel-2 variant.

Test Plan:
- All-zero buffer 0, start with sel=0 -> 512 writes, all coef_di=12289, addresses 0..511 in order, done at cycle 576 after start, exactly 64 bs_en_0 pulses, no bs_en_1 or bs_en_2.
- Buffer 1 word 0 = 0xFF00 repeated -> coef_di 0..7 = 12297. Word 1 = 0x00FF repeated -> coef_di 8..15 = 12281.
- Word with byte pairs (0x01,0x03), (0xF0,0x0F), (0x7F,0x00) in the top 48 bits -> coef_di = 12288, 12289, 12296 at addresses 0, 1, 2.
- start pulsed again during busy, and start with sel=3 while in IDLE -> no effect; the run is unchanged; a single done pulse for the valid run; no done for sel=3.
- rst asserted at cycle 200 of a run -> the next cycle shows coef_we=0, busy=0, bs_en_*=0; no done. A fresh start after refill produces a correct full run.
- Back-to-back runs sel=0, 1, 2 against a SHAKE known-answer fill -> 1536 coefficients match the NewHope C reference poly_sample outputs.
